// File: rtl/spiking_neural_network_xor_if.sv
// rtl/spiking_neural_network_xor_if.sv - host-facing input/result signals of the XOR spiking network
interface spiking_neural_network_xor_if;
  logic in1;
  logic in2;
  logic out;

  modport master (output in1, output in2, input out);
  modport slave (input in1, input in2, output out);
endinterface

// File: rtl/spiking_neural_network_xor.sv
// rtl/spiking_neural_network_xor.sv - integrate-and-fire network computing XOR of two static inputs
module spiking_neural_network_xor #(
  parameter int INT_WIDTH = 4,
  parameter int THRESHOLD = 3,
  parameter int W_EXC     = 2,
  parameter int W_INH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  spiking_neural_network_xor_if.slave   bus
);

  localparam int SW = INT_WIDTH + 3;
  localparam logic signed [SW-1:0] L_EXC  = SW'(W_EXC);
  localparam logic signed [SW-1:0] L_INH  = SW'(W_INH);
  localparam logic signed [SW-1:0] L_THR  = SW'(THRESHOLD);
  localparam logic signed [SW-1:0] L_VMAX = SW'((1 << INT_WIDTH) - 1);

  logic                 r_s1, r_s2;
  logic                 r_h1, r_h2, r_o_fire, r_out;
  logic [INT_WIDTH-1:0] r_v_h1, r_v_h2, r_v_o;

  logic signed [SW-1:0] w_sum_h1, w_sum_h2, w_sum_o;
  logic [INT_WIDTH:0]   w_nxt_h1, w_nxt_h2, w_nxt_o;

  // Returns {fire, next_potential}: fire resets v, otherwise v is clamped into range.
  function automatic logic [INT_WIDTH:0] neuron_step(input logic signed [SW-1:0] sum);
    logic [INT_WIDTH:0] res;
    if (sum >= L_THR) begin
      res = '0;
      res[INT_WIDTH] = 1'b1;
    end else if (sum < 0) begin
      res = '0;
    end else if (sum > L_VMAX) begin
      res = {1'b0, L_VMAX[INT_WIDTH-1:0]};
    end else begin
      res = {1'b0, sum[INT_WIDTH-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    w_sum_h1 = signed'({3'b000, r_v_h1}) + (r_s1 ? L_EXC : '0) - (r_s2 ? L_INH : '0);
    w_sum_h2 = signed'({3'b000, r_v_h2}) + (r_s2 ? L_EXC : '0) - (r_s1 ? L_INH : '0);
    w_sum_o  = signed'({3'b000, r_v_o})  + (r_h1 ? L_EXC : '0) + (r_h2 ? L_EXC : '0);
    w_nxt_h1 = neuron_step(w_sum_h1);
    w_nxt_h2 = neuron_step(w_sum_h2);
    w_nxt_o  = neuron_step(w_sum_o);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_v_h1   <= '0;
      r_v_h2   <= '0;
      r_v_o    <= '0;
      r_h1     <= 1'b0;
      r_h2     <= 1'b0;
      r_o_fire <= 1'b0;
      r_out    <= 1'b0;
    end else begin
      r_s1     <= bus.in1;
      r_s2     <= bus.in2;
      r_h1     <= w_nxt_h1[INT_WIDTH];
      r_v_h1   <= w_nxt_h1[INT_WIDTH-1:0];
      r_h2     <= w_nxt_h2[INT_WIDTH];
      r_v_h2   <= w_nxt_h2[INT_WIDTH-1:0];
      r_o_fire <= w_nxt_o[INT_WIDTH];
      r_v_o    <= w_nxt_o[INT_WIDTH-1:0];
      // Sticky: once O has fired, only reset clears the result.
      r_out    <= r_out | w_nxt_o[INT_WIDTH];
    end
  end

  assign bus.out = r_out;

endmodule

// File: tb/tb_spiking_neural_network_xor.sv
// tb/tb_spiking_neural_network_xor.sv - directed self-checking bench for the XOR spiking network
module tb_spiking_neural_network_xor;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic exp_q[$];

  spiking_neural_network_xor_if bus ();

  spiking_neural_network_xor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out", {7'd0, bus.out}, 8'd0);
    check("rst_vo", {4'd0, dut.r_v_o}, 8'd0);
    check("rst_h", {6'd0, dut.r_h1, dut.r_h2}, 8'd0);
    rst = 1'b0;
  endtask

  // Edge k after reset release: out rises at edge 6 for exactly one high input;
  // the active hidden neuron pulses on edges 3 and 5 only within the first six.
  task automatic run_case(input logic a, input logic b);
    logic exp_h;
    bus.in1 = a;
    bus.in2 = b;
    pulse_reset();
    for (int k = 1; k <= 25; k++) begin
      exp_q.push_back((a ^ b) && (k >= 6));
      @(posedge clk);
      #1;
      check($sformatf("out_%0d%0d_e%0d", a, b, k), {7'd0, bus.out}, {7'd0, exp_q.pop_front()});
      if (k <= 6) begin
        exp_h = (k == 3) || (k == 5);
        check($sformatf("h1_%0d%0d_e%0d", a, b, k), {7'd0, dut.r_h1}, {7'd0, exp_h & a & ~b});
        check($sformatf("h2_%0d%0d_e%0d", a, b, k), {7'd0, dut.r_h2}, {7'd0, exp_h & b & ~a});
      end
      if (a && b) begin
        check($sformatf("vh_11_e%0d", k), {dut.r_v_h1, dut.r_v_h2}, 8'd0);
      end
    end
  endtask

  task automatic wait_out_high(input string tag);
    int cyc;
    cyc = 0;
    while (bus.out !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(tag, {7'd0, bus.out}, 8'd1);
    check({tag, "_bound"}, {7'd0, cyc <= 8}, 8'd1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.in1 = 1'b0;
    bus.in2 = 1'b0;
    @(posedge clk);
    #1;

    run_case(1'b0, 1'b0);
    run_case(1'b0, 1'b1);
    run_case(1'b1, 1'b0);
    run_case(1'b1, 1'b1);

    // Mid-run reset with both inputs high discards the fired result.
    bus.in1 = 1'b1;
    bus.in2 = 1'b0;
    pulse_reset();
    wait_out_high("mid_pre");
    bus.in2 = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out", {7'd0, bus.out}, 8'd0);
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      exp_q.push_back(1'b0);
      @(posedge clk);
      #1;
      check($sformatf("mid_e%0d", k), {7'd0, bus.out}, {7'd0, exp_q.pop_front()});
    end

    // Stickiness: dropping the input after firing keeps out high.
    bus.in1 = 1'b1;
    bus.in2 = 1'b0;
    pulse_reset();
    wait_out_high("stk_pre");
    bus.in1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      exp_q.push_back(1'b1);
      @(posedge clk);
      #1;
      check($sformatf("stk_e%0d", k), {7'd0, bus.out}, {7'd0, exp_q.pop_front()});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spiking_neural_network_xor.md
Name: spiking_neural_network_xor

Overview:
- Small integrate-and-fire spiking network that computes XOR of two static binary inputs.
- Structure: input encoders → two hidden neurons (H1 = in1 AND NOT in2, H2 = in2 AND NOT in1) → one output neuron (OR of H1/H2) → sticky result flag.
- Standalone demo/verification block. A host asserts reset with inputs held stable, waits a bounded number of cycles, then samples `out`.

Parameters:
- INT_WIDTH, 4, bit width of every membrane potential (unsigned); must be ≥3.
- THRESHOLD, 3, firing threshold, compared as `>=`; must be ≤ 2^INT_WIDTH-1.
- W_EXC, 2, excitatory synapse weight.
- W_INH, 4, inhibitory synapse weight; must be ≥ W_EXC.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in1  input  1  binary input A; level, expected stable during evaluation.
- in2  input  1  binary input B.
- out  output 1  registered result; 1 once output neuron has fired since last reset.

Behaviour:
- Reset (rst=1 at a rising edge) clears s1, s2, vH1, vH2, vO, h1, h2, o_fire and out to 0. Reset has priority over all other updates and may occur mid-operation, discarding all state.
- Input encoding: each cycle s1<=in1, s2<=in2. A held-high input therefore produces one spike per cycle.
- Neuron update, identical for H1, H2 and O, using registered spikes from the previous stage:
  - sum = v + Σ(excitatory spikes × W_EXC) − Σ(inhibitory spikes × W_INH), computed in INT_WIDTH+3 signed bits.
  - If sum ≥ THRESHOLD: spike reg <=1 and v <=0.
  - Else: spike reg <=0 and v <= clamp(sum, 0, 2^INT_WIDTH−1).
  - No leak term.
- Connectivity:
  - H1: excitatory s1, inhibitory s2.
  - H2: excitatory s2, inhibitory s1.
  - O: excitatory h1 and h2, no inhibition.
- Output: out <= out | o_fire_next, where o_fire_next is the firing decision for O in that cycle. out is sticky until reset, so a later input change cannot clear it.
- Timing with defaults, counting edges after reset release (edge 1 = first non-reset edge):
  - Single input high: s=1 @1, H fires @3 and @5, O fires @6, out=1 after edge 6.
  - Required bound: out=1 within 8 cycles of reset deassertion whenever exactly one input is high.
- Both inputs high: H potentials see +W_EXC−W_INH ≤ 0 per cycle, clamp at 0 and never fire, so out stays 0 indefinitely.
- Both inputs low: no activity, out stays 0 indefinitely.
- Simultaneous h1 and h2 spikes, possible only if inputs toggle: O adds 2×W_EXC in one cycle; the saturation rule applies.
- Input change after out=1: out remains 1 until the next reset.

Test Plan:
- in1=0,in2=0, 1-cycle reset, wait 25 cycles -> out=0 throughout.
- in1=0,in2=1, reset, wait 25 cycles -> out=1, first high after edge 6; h2 pulses on edges 3 and 5; h1 never pulses.
- in1=1,in2=0 -> out=1 after edge 6; symmetric to the previous case (h1 pulses, h2 silent).
- in1=1,in2=1 -> out=0 after 25 cycles; vH1=vH2=0 every cycle.
- Reset mid-run: in1=1,in2=0 until out=1, then set in2=1 and assert reset for 1 cycle -> out=0 immediately after the reset edge and stays 0 for 25 cycles.
- Stickiness: in1=1,in2=0 until out=1, then in1=0 with no reset -> out stays 1.
